// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared state, opcode, condition and datapath-select encodings.
package control_unit_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_ALUWB,
    S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BRANCH
  } state_t;
  localparam logic [1:0] OP_DPR = 2'b00, OP_DPI = 2'b01, OP_MEM = 2'b10, OP_BR = 2'b11;
  localparam logic [2:0] F_CMP = 3'b100, F_LSL = 3'b110, F_LSR = 3'b111;
  localparam logic [2:0] C_AL = 3'd0, C_EQ = 3'd1, C_NE = 3'd2, C_CS = 3'd3,
                         C_CC = 3'd4, C_MI = 3'd5, C_PL = 3'd6, C_VS = 3'd7;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                         ALU_ORR = 3'b011, ALU_PASSB = 3'b100;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_RDATA = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10;
  localparam logic [2:0] SH_NONE = 3'b000, SH_LSL = 3'b001, SH_LSR = 3'b010;
  function automatic logic [2:0] dp_alu(input logic [2:0] funct);
    return funct[2] ? (funct[1:0] == 2'b00 ? ALU_SUB : ALU_PASSB) : {1'b0, funct[1:0]};
  endfunction
  function automatic logic [2:0] dp_shift(input logic [2:0] funct);
    return funct == F_LSL ? SH_LSL : funct == F_LSR ? SH_LSR : SH_NONE;
  endfunction
endpackage

// File: rtl/control_unit_cond_check.sv
// cond_check: evaluates a 3-bit condition code against the {N,Z,C,V} flags.
module cond_check
  import control_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;
  always_comb begin
    pass = cond == C_AL ? 1'b1 :
           cond == C_EQ ? z :
           cond == C_NE ? !z :
           cond == C_CS ? c :
           cond == C_CC ? !c :
           cond == C_MI ? n :
           cond == C_PL ? !n : v;
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: Moore multi-cycle control FSM with the architectural NZCV flag register.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clk,
  input  logic       RESET,
  input  logic       RUN,
  input  logic [4:0] instr,
  input  logic [2:0] inst3,
  input  logic [3:0] alu_flags,
  output logic [3:0] ALU_flags,
  output logic       adr_source,
  output logic       mem_Write,
  output logic       ir_Write,
  output logic       reg_Write,
  output logic       pc_Write,
  output logic       alu_srcA,
  output logic [1:0] alu_srcB,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] result_src,
  output logic [3:0] RegSrc,
  output logic [2:0] shft_op
);
  state_t state_q, state_d, st;
  logic [3:0] flags_q, flags_d;
  logic [1:0] op;
  logic [2:0] funct;
  logic pass, adv, mw, iw, rw, pw;
  assign {op, funct} = instr;
  assign adv = RUN & !RESET;
  assign ALU_flags = flags_q;
  cond_check u_cond (.cond(inst3), .flags(flags_q), .pass(pass));
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    if (adv) begin
      case (state_q)
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: state_d = !pass ? S_FETCH : op == OP_DPR ? S_EXECR :
                            op == OP_DPI ? S_EXECI : op == OP_MEM ? S_MEMADR : S_BRANCH;
        S_EXECR, S_EXECI: begin
          flags_d = alu_flags;
          state_d = funct == F_CMP ? S_FETCH : S_ALUWB;
        end
        S_MEMADR:  state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: state_d = S_MEMWB;
        default:   state_d = S_FETCH;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= S_FETCH;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end
  // Reset forces the FETCH mux view even before the first reset edge lands.
  assign st = RESET ? S_FETCH : state_q;
  always_comb begin
    {adr_source, mw, iw, rw, pw, alu_srcA} = '0;
    alu_srcB = SRCB_REG;
    alu_control = ALU_ADD;
    imm_src = IMM_DP;
    result_src = RES_ALUOUT;
    RegSrc = '0;
    shft_op = SH_NONE;
    case (st)
      S_FETCH: begin
        {iw, pw, alu_srcA} = 3'b111;
        alu_srcB = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_srcA = 1'b1;
        alu_srcB = SRCB_FOUR;
      end
      S_EXECR, S_EXECI: begin
        alu_srcB = st == S_EXECI ? SRCB_IMM : SRCB_REG;
        alu_control = dp_alu(funct);
        shft_op = dp_shift(funct);
      end
      S_ALUWB: rw = 1'b1;
      S_MEMADR: begin
        alu_srcB = SRCB_IMM;
        imm_src = IMM_MEM;
        alu_control = funct[1] ? ALU_ADD : ALU_SUB;
        RegSrc = 4'b0010;
      end
      S_MEMREAD: adr_source = 1'b1;
      S_MEMWB: begin
        result_src = RES_RDATA;
        rw = 1'b1;
      end
      S_MEMWRITE: begin
        {adr_source, mw} = 2'b11;
        RegSrc = 4'b0010;
      end
      S_BRANCH: begin
        {pw, alu_srcA} = 2'b11;
        rw = funct[0];
        alu_srcB = SRCB_IMM;
        imm_src = IMM_BR;
        result_src = RES_ALU;
        RegSrc = funct[0] ? 4'b1101 : 4'b0001;
      end
      default: ;
    endcase
  end
  assign mem_Write = mw & adv;
  assign ir_Write = iw & adv;
  assign reg_Write = rw & adv;
  assign pc_Write = pw & adv;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-cycle vectors with a queued scoreboard checked by a negedge monitor.
module tb_control_unit;
  logic clk = 0, RESET = 1, RUN = 0;
  logic [4:0] instr = '0;
  logic [2:0] inst3 = '0;
  logic [3:0] alu_flags = '0;
  logic [3:0] ALU_flags, RegSrc;
  logic adr_source, mem_Write, ir_Write, reg_Write, pc_Write, alu_srcA;
  logic [1:0] alu_srcB, imm_src, result_src;
  logic [2:0] alu_control, shft_op;
  typedef struct { logic [25:0] exp; string name; } item_t;
  item_t sb[$];
  int applied = 0, miscompares = 0;
  control_unit dut (
    .clk(clk), .RESET(RESET), .RUN(RUN), .instr(instr), .inst3(inst3),
    .alu_flags(alu_flags), .ALU_flags(ALU_flags), .adr_source(adr_source),
    .mem_Write(mem_Write), .ir_Write(ir_Write), .reg_Write(reg_Write), .pc_Write(pc_Write),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_control(alu_control), .imm_src(imm_src),
    .result_src(result_src), .RegSrc(RegSrc), .shft_op(shft_op)
  );
  always #5 clk = ~clk;
  // Packed view: flags, adr, {mem,ir,reg,pc}, srcA, srcB, alu, imm, result, RegSrc, shift.
  function automatic logic [25:0] o(input logic [3:0] fl, input logic adr, input logic [3:0] we,
      input logic sa, input logic [1:0] sbx, input logic [2:0] ac, input logic [1:0] is,
      input logic [1:0] rs, input logic [3:0] rsrc, input logic [2:0] sh);
    return {fl, adr, we, sa, sbx, ac, is, rs, rsrc, sh};
  endfunction
  task automatic vec(input string nm, input logic rst, input logic run, input logic [4:0] in,
      input logic [2:0] c, input logic [3:0] af, input logic [25:0] exp);
    item_t it;
    @(posedge clk);
    #1;
    {RESET, RUN, instr, inst3, alu_flags} = {rst, run, in, c, af};
    it.exp = exp;
    it.name = nm;
    sb.push_back(it);
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      logic [25:0] got;
      it = sb.pop_front();
      got = {ALU_flags, adr_source, mem_Write, ir_Write, reg_Write, pc_Write, alu_srcA,
             alu_srcB, alu_control, imm_src, result_src, RegSrc, shft_op};
      applied++;
      if (got !== it.exp) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b", it.name, got, it.exp);
      end
    end
  end
  initial begin
    vec("reset_hold",   1, 1, 5'b00000, 3'd0, 4'b0000, o(4'h0, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("add_fetch",    0, 1, 5'b00000, 3'd0, 4'b0000, o(4'h0, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("add_decode",   0, 1, 5'b00000, 3'd0, 4'b0000, o(4'h0, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("add_execr",    0, 1, 5'b00000, 3'd0, 4'b0000, o(4'h0, 0, 4'b0000, 0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("add_aluwb",    0, 1, 5'b00000, 3'd0, 4'b0000, o(4'h0, 0, 4'b0010, 0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("cmp_fetch",    0, 1, 5'b00100, 3'd0, 4'b0000, o(4'h0, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("cmp_decode",   0, 1, 5'b00100, 3'd0, 4'b0000, o(4'h0, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("cmp_execr",    0, 1, 5'b00100, 3'd0, 4'b0100, o(4'h0, 0, 4'b0000, 0, 2'b00, 3'b001, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("ne_fetch",     0, 1, 5'b00000, 3'd2, 4'b0000, o(4'h4, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("ne_decode",    0, 1, 5'b00000, 3'd2, 4'b0000, o(4'h4, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("eq_fetch",     0, 1, 5'b00000, 3'd1, 4'b0000, o(4'h4, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("eq_decode",    0, 1, 5'b00000, 3'd1, 4'b0000, o(4'h4, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("eq_execr",     0, 1, 5'b00000, 3'd1, 4'b0011, o(4'h4, 0, 4'b0000, 0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("eq_aluwb",     0, 1, 5'b00000, 3'd1, 4'b0000, o(4'h3, 0, 4'b0010, 0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("ldr_fetch",    0, 1, 5'b10011, 3'd0, 4'b0000, o(4'h3, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("ldr_decode",   0, 1, 5'b10011, 3'd0, 4'b0000, o(4'h3, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("ldr_memadr",   0, 1, 5'b10011, 3'd0, 4'b0000, o(4'h3, 0, 4'b0000, 0, 2'b01, 3'b000, 2'b01, 2'b00, 4'h2, 3'b000));
    vec("ldr_memread",  0, 1, 5'b10011, 3'd0, 4'b0000, o(4'h3, 1, 4'b0000, 0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("ldr_memwb",    0, 1, 5'b10011, 3'd0, 4'b0000, o(4'h3, 0, 4'b0010, 0, 2'b00, 3'b000, 2'b00, 2'b01, 4'h0, 3'b000));
    vec("str_fetch",    0, 1, 5'b10000, 3'd0, 4'b0000, o(4'h3, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("str_decode",   0, 1, 5'b10000, 3'd0, 4'b0000, o(4'h3, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("str_memadr",   0, 1, 5'b10000, 3'd0, 4'b0000, o(4'h3, 0, 4'b0000, 0, 2'b01, 3'b001, 2'b01, 2'b00, 4'h2, 3'b000));
    vec("str_memwrite", 0, 1, 5'b10000, 3'd0, 4'b0000, o(4'h3, 1, 4'b1000, 0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h2, 3'b000));
    vec("bl_fetch",     0, 1, 5'b11001, 3'd0, 4'b0000, o(4'h3, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("bl_decode",    0, 1, 5'b11001, 3'd0, 4'b0000, o(4'h3, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("bl_branch",    0, 1, 5'b11001, 3'd0, 4'b0000, o(4'h3, 0, 4'b0011, 1, 2'b01, 3'b000, 2'b10, 2'b10, 4'hd, 3'b000));
    vec("lsli_fetch",   0, 1, 5'b01110, 3'd0, 4'b0000, o(4'h3, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("lsli_decode",  0, 1, 5'b01110, 3'd0, 4'b0000, o(4'h3, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("lsli_frz1",    0, 0, 5'b01110, 3'd0, 4'b1000, o(4'h3, 0, 4'b0000, 0, 2'b01, 3'b100, 2'b00, 2'b00, 4'h0, 3'b001));
    vec("lsli_frz2",    0, 0, 5'b01110, 3'd0, 4'b1000, o(4'h3, 0, 4'b0000, 0, 2'b01, 3'b100, 2'b00, 2'b00, 4'h0, 3'b001));
    vec("lsli_execi",   0, 1, 5'b01110, 3'd0, 4'b1000, o(4'h3, 0, 4'b0000, 0, 2'b01, 3'b100, 2'b00, 2'b00, 4'h0, 3'b001));
    vec("lsli_aluwb",   0, 1, 5'b01110, 3'd0, 4'b0000, o(4'h8, 0, 4'b0010, 0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("fetch_frz",    0, 0, 5'b00111, 3'd0, 4'b0000, o(4'h8, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("lsr_fetch",    0, 1, 5'b00111, 3'd0, 4'b0000, o(4'h8, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("lsr_decode",   0, 1, 5'b00111, 3'd0, 4'b0000, o(4'h8, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("lsr_execr",    0, 1, 5'b00111, 3'd0, 4'b0001, o(4'h8, 0, 4'b0000, 0, 2'b00, 3'b100, 2'b00, 2'b00, 4'h0, 3'b010));
    vec("lsr_aluwb",    0, 1, 5'b00111, 3'd0, 4'b0000, o(4'h1, 0, 4'b0010, 0, 2'b00, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("abort_fetch",  0, 1, 5'b10011, 3'd0, 4'b0000, o(4'h1, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("abort_decode", 0, 1, 5'b10011, 3'd0, 4'b0000, o(4'h1, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("abort_reset",  1, 1, 5'b10011, 3'd0, 4'b0000, o(4'h1, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("cs_fetch",     0, 1, 5'b00000, 3'd3, 4'b0000, o(4'h0, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    vec("cs_decode",    0, 1, 5'b00000, 3'd3, 4'b0000, o(4'h0, 0, 4'b0000, 1, 2'b10, 3'b000, 2'b00, 2'b00, 4'h0, 3'b000));
    vec("cs_refetch",   0, 1, 5'b00000, 3'd3, 4'b0000, o(4'h0, 0, 4'b0101, 1, 2'b10, 3'b000, 2'b00, 2'b10, 4'h0, 3'b000));
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
